// File: rtl/lc3b_pkg.sv
// Shared definitions for the LC-3b style fetch path.
//   WORD_W           - datapath word width
//   PC_STEP          - PC increment per fetched instruction (bytes)
//   PC_RESET_DEFAULT - default PC after reset
//   fetch_state_e    - fetch sequencer states
package lc3b_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned PC_STEP = 2;

  localparam logic [WORD_W-1:0] PC_RESET_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StMar,
    StRead,
    StIrld
  } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// Memory-wait counter for the fetch sequencer.
//   clk_i     - clock
//   rst_ni    - asynchronous active-low reset
//   clr_i     - clear the counter (has priority over inc_i)
//   inc_i     - increment the counter
//   expired_o - counter has reached Timeout-1 (last allowed wait cycle)
module fetch_timer #(
  parameter int unsigned Timeout = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 8'(Timeout - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer feeding the instruction register.
// Sequence: IDLE -> MAR (latch PC into MAR) -> READ (wait for mem_r, capture MDR,
// PC += 2) -> IRLD (pulse ld_ir/done) -> IDLE. A READ that sees no mem_r for
// MEM_TIMEOUT cycles aborts back to IDLE and pulses timeout_err one cycle later.
//   clock_50    - clock
//   reset_n     - asynchronous active-low reset
//   start       - fetch request (IDLE only)
//   ld_pc       - load PC from pc_in (IDLE only, bit 0 forced to 0)
//   pc_in       - branch/jump target
//   mem_addr    - MAR contents
//   mem_en      - memory read enable (READ state)
//   mem_r       - memory ready, data valid same cycle
//   mem_data    - memory read data
//   ir_data     - MDR contents, to IR data input
//   ld_ir       - IR load enable (IRLD state)
//   pc          - current PC
//   busy        - not IDLE
//   done        - coincident with ld_ir
//   timeout_err - one-cycle pulse after an aborted fetch
module fetch_unit
  import lc3b_pkg::*;
#(
  parameter int unsigned            DATA_W      = WORD_W,
  parameter logic [DATA_W-1:0]      PC_RESET    = PC_RESET_DEFAULT,
  parameter int unsigned            MEM_TIMEOUT = 15
) (
  input  logic              clock_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              ld_pc,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic              mem_r,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] ir_data,
  output logic              ld_ir,
  output logic [DATA_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              timeout_q, abort;
  logic              timer_clr, timer_inc, timer_expired;

  // PC is always halfword aligned; the target's LSB is dropped.
  logic unused_pc_in_lsb;
  assign unused_pc_in_lsb = pc_in[0];

  fetch_timer #(
    .Timeout (MEM_TIMEOUT)
  ) u_fetch_timer (
    .clk_i     (clock_50),
    .rst_ni    (reset_n),
    .clr_i     (timer_clr),
    .inc_i     (timer_inc),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    timer_clr = 1'b0;
    timer_inc = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A simultaneous ld_pc/start fetches from the new PC: MAR reads pc_q
        // one cycle later, after the load has landed.
        if (ld_pc) begin
          pc_d = {pc_in[DATA_W-1:1], 1'b0};
        end
        if (start) begin
          state_d = StMar;
        end
      end
      StMar: begin
        mar_d     = pc_q;
        timer_clr = 1'b1;
        state_d   = StRead;
      end
      StRead: begin
        // Ready wins over expiry so the last allowed cycle still succeeds.
        if (mem_r) begin
          mdr_d   = mem_data;
          pc_d    = pc_q + DATA_W'(PC_STEP);
          state_d = StIrld;
        end else if (timer_expired) begin
          abort   = 1'b1;
          state_d = StIdle;
        end else begin
          timer_inc = 1'b1;
        end
      end
      StIrld: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      pc_q      <= PC_RESET;
      mar_q     <= '0;
      mdr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      timeout_q <= abort;
    end
  end

  assign mem_addr    = mar_q;
  assign ir_data     = mdr_q;
  assign pc          = pc_q;
  assign mem_en      = (state_q == StRead);
  assign ld_ir       = (state_q == StIrld);
  assign done        = (state_q == StIrld);
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clock_50;
  logic        reset_n;
  logic        start;
  logic        ld_pc;
  logic [15:0] pc_in;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_r;
  logic [15:0] mem_data;
  logic [15:0] ir_data;
  logic        ld_ir;
  logic [15:0] pc;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  // Per-fetch observations filled in by run_fetch.
  int          r_en_cnt, r_first_en, r_ld_cnt, r_ld_cyc, r_to_cnt, r_end_cyc, r_done_bad;
  logic [15:0] r_addr, r_ir;

  fetch_unit #(
    .DATA_W      (16),
    .PC_RESET    (16'h0000),
    .MEM_TIMEOUT (15)
  ) dut (
    .clock_50    (clock_50),
    .reset_n     (reset_n),
    .start       (start),
    .ld_pc       (ld_pc),
    .pc_in       (pc_in),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_r       (mem_r),
    .mem_data    (mem_data),
    .ir_data     (ir_data),
    .ld_ir       (ld_ir),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  initial begin
    clock_50 = 1'b0;
    forever #5 clock_50 = ~clock_50;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  // Starts a fetch from the current IDLE cycle (cycle 0). The memory answers
  // on READ cycle number waits+1. Cycles are counted from 1 after cycle 0.
  task automatic run_fetch(input logic do_ld, input logic [15:0] tgt, input int waits,
                           input logic [15:0] data);
    bit finished = 0;
    r_en_cnt = 0; r_first_en = 0; r_ld_cnt = 0; r_ld_cyc = 0;
    r_to_cnt = 0; r_end_cyc = 0; r_done_bad = 0; r_addr = 16'hxxxx; r_ir = 16'hxxxx;
    ld_pc = do_ld; pc_in = tgt; start = 1'b1; mem_r = 1'b0; mem_data = data;
    for (int c = 1; c <= 40 && !finished; c++) begin
      tick();
      start = 1'b0;
      ld_pc = 1'b0;
      if (mem_en) begin
        r_en_cnt++;
        if (r_first_en == 0) r_first_en = c;
        r_addr = mem_addr;
      end
      mem_r = mem_en && (r_en_cnt > waits);
      if (ld_ir) begin
        r_ld_cnt++;
        r_ld_cyc = c;
        r_ir = ir_data;
      end
      if (done != ld_ir) r_done_bad++;
      if (timeout_err) r_to_cnt++;
      if (!busy) begin
        finished = 1;
        r_end_cyc = c;
      end
    end
    mem_r = 1'b0;
    check_eq("fetch_terminates", 32'(finished), 32'd1);
  endtask

  initial begin
    int ldc;
    bit c3, c7;
    reset_n = 1'b0; start = 1'b0; ld_pc = 1'b0; pc_in = '0; mem_r = 1'b0; mem_data = '0;

    // Reset state
    #2;
    check_eq("rst_pc", 32'(pc), 32'h0000);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0000);
    check_eq("rst_ir_data", 32'(ir_data), 32'h0000);
    check_eq("rst_outs", {27'd0, mem_en, ld_ir, done, busy, timeout_err}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;

    // Zero-wait fetch from PC_RESET
    run_fetch(1'b0, 16'h0000, 0, 16'h1234);
    check_eq("t1_first_en", 32'(r_first_en), 32'd2);
    check_eq("t1_addr", 32'(r_addr), 32'h0000);
    check_eq("t1_ld_cyc", 32'(r_ld_cyc), 32'd3);
    check_eq("t1_ld_cnt", 32'(r_ld_cnt), 32'd1);
    check_eq("t1_ir", 32'(r_ir), 32'h1234);
    check_eq("t1_pc", 32'(pc), 32'h0002);
    check_eq("t1_end", 32'(r_end_cyc), 32'd4);
    check_eq("t1_done", 32'(r_done_bad), 32'd0);

    // ld_pc and start together: fetch uses new PC, LSB dropped
    run_fetch(1'b1, 16'h3001, 0, 16'hABCD);
    check_eq("t2_addr", 32'(r_addr), 32'h3000);
    check_eq("t2_pc", 32'(pc), 32'h3002);
    check_eq("t2_ir", 32'(ir_data), 32'hABCD);

    // Three wait cycles
    run_fetch(1'b0, 16'h0000, 3, 16'h5A5A);
    check_eq("t3_en_cnt", 32'(r_en_cnt), 32'd4);
    check_eq("t3_ld_cyc", 32'(r_ld_cyc), 32'd6);
    check_eq("t3_ld_cnt", 32'(r_ld_cnt), 32'd1);
    check_eq("t3_pc", 32'(pc), 32'h3004);
    check_eq("t3_ir", 32'(r_ir), 32'h5A5A);

    // Memory never ready: abort after 15 READ cycles
    run_fetch(1'b0, 16'h0000, 1000, 16'hDEAD);
    check_eq("t4_en_cnt", 32'(r_en_cnt), 32'd15);
    check_eq("t4_end", 32'(r_end_cyc), 32'd17);
    check_eq("t4_ld_cnt", 32'(r_ld_cnt), 32'd0);
    check_eq("t4_to_cnt", 32'(r_to_cnt), 32'd1);
    check_eq("t4_pc", 32'(pc), 32'h3004);
    check_eq("t4_ir", 32'(ir_data), 32'h5A5A);
    tick();
    check_eq("t4_to_pulse", 32'(timeout_err), 32'd0);

    // PC wrap at top of memory
    run_fetch(1'b1, 16'hFFFF, 0, 16'h0F0F);
    check_eq("t5_addr", 32'(r_addr), 32'hFFFE);
    check_eq("t5_pc", 32'(pc), 32'h0000);
    check_eq("t5_ir", 32'(ir_data), 32'h0F0F);

    // Back-to-back with start held; ld_pc asserted only while busy must be ignored
    start = 1'b1; mem_r = 1'b0; mem_data = 16'h7777; pc_in = 16'h1230;
    ldc = 0; c3 = 0; c7 = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) start = 1'b0;
      ld_pc = busy;
      mem_r = mem_en;
      if (ld_ir) begin
        ldc++;
        if (c == 3) c3 = 1;
        if (c == 7) c7 = 1;
      end
    end
    ld_pc = 1'b0; mem_r = 1'b0;
    check_eq("t6_ld_cnt", 32'(ldc), 32'd2);
    check_eq("t6_period", {30'd0, c3, c7}, 32'd3);
    check_eq("t6_pc", 32'(pc), 32'h0004);
    tick();
    check_eq("t6_idle", 32'(busy), 32'd0);

    // Reset asserted during READ
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("t7_in_read", 32'(mem_en), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t7_en_async", 32'(mem_en), 32'd0);
    check_eq("t7_pc", 32'(pc), 32'h0000);
    check_eq("t7_busy", 32'(busy), 32'd0);
    check_eq("t7_ir", 32'(ir_data), 32'h0000);
    tick();
    check_eq("t7_no_ld", 32'(ld_ir), 32'd0);
    reset_n = 1'b1;
    run_fetch(1'b0, 16'h0000, 0, 16'h4321);
    check_eq("t7_addr", 32'(r_addr), 32'h0000);
    check_eq("t7_ld_cnt", 32'(r_ld_cnt), 32'd1);
    check_eq("t7_ir2", 32'(r_ir), 32'h4321);
    check_eq("t7_pc2", 32'(pc), 32'h0002);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer that sits directly upstream of the instruction register.
- Holds the PC, copies it to the memory address (MAR), and drives a memory read that waits on a ready handshake.
- Captures the read word in an internal MDR and advances PC by 2.
- Then pulses the IR load-enable with the fetched word on ir_data, which feeds the IR's in and load inputs.

Parameters:
- DATA_W, 16, word width of PC, MAR, MDR and ir_data.
- PC_RESET, 16'h0000, PC value after reset; bit 0 must be 0.
- MEM_TIMEOUT, 15, max READ-state cycles without mem_r before the fetch aborts; range 1..255.

Ports:
- clock_50  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  fetch request; sampled only in IDLE.
- ld_pc  in  1  load PC from pc_in; honoured only in IDLE.
- pc_in  in  16  branch/jump target; bit 0 ignored.
- mem_addr  out  16  MAR contents.
- mem_en  out  1  memory read enable.
- mem_r  in  1  memory ready; data valid in the same cycle.
- mem_data  in  16  memory read data.
- ir_data  out  16  MDR contents; connect to the IR's data input.
- ld_ir  out  1  one-cycle IR load enable.
- pc  out  16  current PC.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse coincident with ld_ir.
- timeout_err  out  1  one-cycle pulse when a fetch aborts.

Behaviour:
- Reset (reset_n=0, immediate, asynchronous):
  - State=IDLE, pc=PC_RESET.
  - mem_addr=0, MDR/ir_data=0.
  - mem_en=0, ld_ir=0, done=0, busy=0, timeout_err=0, wait counter=0.
- Reset mid-fetch abandons the fetch: no ld_ir, PC reverts to PC_RESET.
- States are IDLE, MAR, READ, IRLD. mem_en, ld_ir, done and busy are decoded from the state register.
- IDLE:
  - If ld_pc=1: pc<={pc_in[15:1],1'b0}.
  - If start=1: go to MAR.
  - If both are high in the same cycle: PC loads first, and the fetch uses the new PC.
- MAR:
  - mem_addr<=pc, wait counter cleared.
  - Next state READ.
- READ:
  - mem_en=1.
  - If mem_r=1: MDR<=mem_data, pc<=pc+2 (modulo 2^16, so 16'hFFFE wraps to 16'h0000), next state IRLD.
  - Otherwise the counter increments. When the counter reaches MEM_TIMEOUT-1 with mem_r still 0: next state IDLE, timeout_err pulses in the following cycle, PC and MDR unchanged.
  - mem_r=1 on the final allowed cycle counts as success, not a timeout.
- IRLD:
  - ld_ir=1, done=1, ir_data stable.
  - Next state IDLE.
- Latency:
  - Zero-wait memory: start sampled at edge 0, MAR in cycle 1, READ in cycle 2, ld_ir high in cycle 3, IR captures at end of cycle 3.
  - Each cycle of mem_r low adds one cycle.
- Ignored inputs:
  - start and ld_pc outside IDLE are ignored and not queued.
  - mem_r outside READ is ignored.
- Back-to-back fetches: start held high re-enters MAR on the cycle after IRLD's return to IDLE, giving a 4-cycle fetch period with zero-wait memory.
- ir_data holds the last fetched word until the next successful READ.

Decomposition:
- Shared package lc3b_pkg:
  - fetch-state enumeration (IDLE, MAR, READ, IRLD);
  - WORD_W=16;
  - PC_STEP=2;
  - PC_RESET default.
- One sub-module, fetch_timer: 8-bit wait counter with clear and increment inputs and an expired output at MEM_TIMEOUT-1.
- The PC, MAR and MDR registers stay inline.

Test Plan:
- Reset then start=1 for one cycle; memory returns 16'h1234 with mem_r=1 immediately:
  - mem_addr=0000 and mem_en high in cycle 2;
  - ld_ir/done high in cycle 3 with ir_data=1234;
  - pc=0002; busy low from cycle 4.
- ld_pc=1, pc_in=16'h3001 and start=1 in the same IDLE cycle:
  - mem_addr=3000;
  - after fetch pc=3002.
- mem_r delayed 3 cycles: mem_en held 4 cycles, ld_ir in cycle 6, exactly one ld_ir pulse.
- mem_r never asserted, MEM_TIMEOUT=15:
  - mem_en high for 15 cycles, then IDLE;
  - timeout_err one-cycle pulse; pc and ir_data unchanged; no ld_ir.
- pc=16'hFFFE, fetch completes: pc=0000, mem_addr was FFFE.
- reset_n dropped during READ:
  - mem_en falls without waiting for a clock edge; pc=PC_RESET; no ld_ir;
  - start after release fetches from PC_RESET.
